// File: rtl/serial_byte_collector_pkg.sv
// Shared types and widths for the serial byte collector.
package serial_byte_collector_pkg;
   localparam int BYTE_W    = 8;
   localparam int BIT_CNT_W = 3;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;
endpackage

// File: rtl/serial_byte_collector_if.sv
// Serial-in and byte-out handshake signals of the collector.
interface serial_byte_collector_if;
   import serial_byte_collector_pkg::*;

   logic              sin_valid;
   logic              sin_data;
   logic              sin_ready;
   logic              out_valid;
   logic [BYTE_W-1:0] out_data;
   logic              out_ready;
   logic              out_any;

   modport slave (
      input  sin_valid, sin_data, out_ready,
      output sin_ready, out_valid, out_data, out_any
   );

   modport master (
      output sin_valid, sin_data, out_ready,
      input  sin_ready, out_valid, out_data, out_any
   );
endinterface

// File: rtl/or_gate_8.sv
// Eight-input OR reduction.
module or_gate_8 (
   input  logic [7:0] a,
   output logic       y
);
   assign y = |a;
endmodule

// File: rtl/serial_byte_collector.sv
// Assembles 8 serial bits into a byte, holds it until handed off downstream,
// and keeps a saturating count of all-zero bytes delivered.
module serial_byte_collector
   import serial_byte_collector_pkg::*;
#(
   parameter int LSB_FIRST = 1,
   parameter int ZCNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   serial_byte_collector_if.slave  bus,
   output logic [BIT_CNT_W-1:0]    bit_cnt,
   output logic [ZCNT_W-1:0]       zero_cnt
);

   state_t              state_q, state_d;
   // Only 7 bits of a partial word ever need storing; the 8th arrives with the completing accept.
   logic [BYTE_W-2:0]   partial_q, partial_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [BYTE_W-1:0]   out_data_q, out_data_d;
   logic [ZCNT_W-1:0]   zero_cnt_q, zero_cnt_d;

   logic                sin_ready;
   logic                accept;
   logic                handshake;
   logic                out_any_w;
   logic [BYTE_W-2:0]   partial_shift;
   logic [BYTE_W-1:0]   byte_done;

   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign partial_shift = {bus.sin_data, partial_q[BYTE_W-2:1]};
         assign byte_done     = {bus.sin_data, partial_q};
      end else begin : g_msb
         assign partial_shift = {partial_q[BYTE_W-3:0], bus.sin_data};
         assign byte_done     = {partial_q, bus.sin_data};
      end
   endgenerate

   or_gate_8 u_or_gate_8 (
      .a (out_data_q),
      .y (out_any_w)
   );

   assign sin_ready = (state_q == COLLECT) ? 1'b1 : bus.out_ready;
   assign accept    = bus.sin_valid && sin_ready;
   assign handshake = (state_q == FULL) && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      partial_d   = partial_q;
      bit_cnt_d   = bit_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      zero_cnt_d  = zero_cnt_q;

      if (flush) begin
         state_d     = COLLECT;
         partial_d   = '0;
         bit_cnt_d   = '0;
         out_valid_d = 1'b0;
      end else begin
         if (handshake) begin
            out_valid_d = 1'b0;
            state_d     = COLLECT;
            if (!out_any_w && (zero_cnt_q != '1)) begin
               zero_cnt_d = zero_cnt_q + ZCNT_W'(1);
            end
         end
         // A bit taken during a handshake starts the next word, so bit_cnt goes 0 -> 1 here.
         if (accept) begin
            partial_d = partial_shift;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if ((state_q == COLLECT) && (bit_cnt_q == '1)) begin
               out_data_d  = byte_done;
               out_valid_d = 1'b1;
               state_d     = FULL;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         partial_q   <= '0;
         bit_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         zero_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         partial_q   <= partial_d;
         bit_cnt_q   <= bit_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         zero_cnt_q  <= zero_cnt_d;
      end
   end

   assign bus.sin_ready = sin_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_any   = out_any_w;
   assign bit_cnt       = bit_cnt_q;
   assign zero_cnt      = zero_cnt_q;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Scoreboard bench driving an LSB-first (2-bit counter) and an MSB-first (8-bit counter) collector in lockstep.
module tb_serial_byte_collector;
   import serial_byte_collector_pkg::*;

   logic clk;
   logic rst;
   logic flush;
   logic [BIT_CNT_W-1:0] bit_cnt_a, bit_cnt_b;
   logic [1:0]           zero_cnt_a;
   logic [7:0]           zero_cnt_b;

   int checks   = 0;
   int failures = 0;

   logic [8:0] q_a[$];
   logic [8:0] q_b[$];
   logic       pv_a = 1'b0;
   logic       pv_b = 1'b0;

   serial_byte_collector_if ifa ();
   serial_byte_collector_if ifb ();

   serial_byte_collector #(.LSB_FIRST(1), .ZCNT_W(2)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .bus      (ifa),
      .bit_cnt  (bit_cnt_a),
      .zero_cnt (zero_cnt_a)
   );

   serial_byte_collector #(.LSB_FIRST(0), .ZCNT_W(8)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .bus      (ifb),
      .bit_cnt  (bit_cnt_b),
      .zero_cnt (zero_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual='h%0h required='h%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic d, input logic r, input logic f, input logic rs);
      ifa.sin_valid = v;  ifb.sin_valid = v;
      ifa.sin_data  = d;  ifb.sin_data  = d;
      ifa.out_ready = r;  ifb.out_ready = r;
      flush = f;
      rst   = rs;
   endtask

   task automatic cyc(input logic v, input logic d, input logic r, input logic f, input logic rs);
      set_in(v, d, r, f, rs);
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_A_valid"}, int'(ifa.out_valid), 0);
      chk({tag, "_B_valid"}, int'(ifb.out_valid), 0);
      chk({tag, "_A_data"},  int'(ifa.out_data), 0);
      chk({tag, "_B_data"},  int'(ifb.out_data), 0);
      chk({tag, "_A_any"},   int'(ifa.out_any), 0);
      chk({tag, "_A_bitcnt"}, int'(bit_cnt_a), 0);
      chk({tag, "_B_bitcnt"}, int'(bit_cnt_b), 0);
      chk({tag, "_A_zcnt"},  int'(zero_cnt_a), 0);
      chk({tag, "_B_zcnt"},  int'(zero_cnt_b), 0);
      chk({tag, "_A_sready"}, int'(ifa.sin_ready), 1);
      chk({tag, "_B_sready"}, int'(ifb.sin_ready), 1);
   endtask

   // Monitor: each new byte presentation pops one expected {any, data} per DUT.
   always begin
      logic [8:0] e;
      @(posedge clk);
      #1;
      if (ifa.out_valid && !pv_a) begin
         if (q_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL A_unexpected_byte actual='h%0h required=none", ifa.out_data);
         end else begin
            e = q_a.pop_front();
            chk("A_byte_data", int'(ifa.out_data), int'(e[7:0]));
            chk("A_byte_any", int'(ifa.out_any), int'(e[8]));
            $display("byte A data='h%02h any=%0d", ifa.out_data, ifa.out_any);
         end
      end
      if (ifb.out_valid && !pv_b) begin
         if (q_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL B_unexpected_byte actual='h%0h required=none", ifb.out_data);
         end else begin
            e = q_b.pop_front();
            chk("B_byte_data", int'(ifb.out_data), int'(e[7:0]));
            chk("B_byte_any", int'(ifb.out_any), int'(e[8]));
            $display("byte B data='h%02h any=%0d", ifb.out_data, ifb.out_any);
         end
      end
      pv_a = ifa.out_valid;
      pv_b = ifb.out_valid;
   end

   initial begin
      logic [7:0] pat;
      int za[5] = '{1, 2, 3, 3, 3};
      int zb[5] = '{1, 2, 3, 4, 5};

      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      chk_reset("reset");

      // 1,0,1,1,0,0,1,0 : LSB-first 0x4D, MSB-first 0xB2
      pat = 8'h4D;
      q_a.push_back({1'b1, 8'h4D});
      q_b.push_back({1'b1, 8'hB2});
      for (int i = 0; i < 8; i++) begin
         cyc(1, pat[i], 0, 0, 0);
         if (i == 6) begin
            chk("lat_A_valid_before", int'(ifa.out_valid), 0);
            chk("lat_A_bitcnt7", int'(bit_cnt_a), 7);
            chk("lat_B_bitcnt7", int'(bit_cnt_b), 7);
         end
      end
      chk("lat_A_valid", int'(ifa.out_valid), 1);
      chk("lat_B_valid", int'(ifb.out_valid), 1);
      chk("lat_A_bitcnt0", int'(bit_cnt_a), 0);

      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 0, 0, 0);
         chk("stall_A_sready", int'(ifa.sin_ready), 0);
         chk("stall_B_sready", int'(ifb.sin_ready), 0);
         chk("stall_A_bitcnt", int'(bit_cnt_a), 0);
         chk("stall_A_data", int'(ifa.out_data), 'h4D);
         chk("stall_B_data", int'(ifb.out_data), 'hB2);
         chk("stall_A_valid", int'(ifa.out_valid), 1);
      end
      set_in(1, 1, 1, 0, 0);
      #1;
      chk("hs_A_sready", int'(ifa.sin_ready), 1);
      chk("hs_B_sready", int'(ifb.sin_ready), 1);
      @(negedge clk);
      chk("hs_A_valid", int'(ifa.out_valid), 0);
      chk("hs_A_bitcnt", int'(bit_cnt_a), 1);
      chk("hs_B_bitcnt", int'(bit_cnt_b), 1);
      chk("hs_B_zcnt", int'(zero_cnt_b), 0);

      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("pre_flush_A_bitcnt", int'(bit_cnt_a), 3);
      cyc(1, 1, 0, 1, 0);
      chk("flush_A_bitcnt", int'(bit_cnt_a), 0);
      chk("flush_B_bitcnt", int'(bit_cnt_b), 0);
      chk("flush_A_valid", int'(ifa.out_valid), 0);
      q_a.push_back({1'b1, 8'hFF});
      q_b.push_back({1'b1, 8'hFF});
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (i == 6) chk("flush_drop_A_valid7", int'(ifa.out_valid), 0);
      end
      chk("ff_A_valid", int'(ifa.out_valid), 1);
      cyc(0, 0, 1, 0, 0);
      chk("ff_hs_A_valid", int'(ifa.out_valid), 0);
      chk("ff_hs_A_zcnt", int'(zero_cnt_a), 0);
      chk("ff_hs_B_zcnt", int'(zero_cnt_b), 0);

      for (int k = 0; k < 5; k++) begin
         q_a.push_back({1'b0, 8'h00});
         q_b.push_back({1'b0, 8'h00});
         for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0);
         chk("zero_A_valid", int'(ifa.out_valid), 1);
         cyc(0, 0, 1, 0, 0);
         chk("zero_A_hs_valid", int'(ifa.out_valid), 0);
         chk("zero_A_zcnt", int'(zero_cnt_a), za[k]);
         chk("zero_B_zcnt", int'(zero_cnt_b), zb[k]);
      end

      q_a.push_back({1'b0, 8'h00});
      q_b.push_back({1'b0, 8'h00});
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
      chk("fhs_A_valid", int'(ifa.out_valid), 1);
      cyc(1, 1, 1, 1, 0);
      chk("fhs_A_valid_after", int'(ifa.out_valid), 0);
      chk("fhs_A_bitcnt", int'(bit_cnt_a), 0);
      chk("fhs_A_zcnt", int'(zero_cnt_a), 3);
      chk("fhs_B_zcnt", int'(zero_cnt_b), 5);

      q_a.push_back({1'b1, 8'hFF});
      q_b.push_back({1'b1, 8'hFF});
      for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
      chk("rst_A_valid_before", int'(ifa.out_valid), 1);
      cyc(0, 0, 0, 0, 1);
      chk_reset("midrst");
      cyc(0, 0, 0, 0, 0);
      chk("A_queue_drained", q_a.size(), 0);
      chk("B_queue_drained", q_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
